// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its host: serial line, frame
// configuration, and the received word with its status pulses.
interface uart_rx_if #(
   parameter int Data_Width = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [Data_Width-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  Par_Err;
   logic                  Stp_Err;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, Data_Valid, Par_Err, Stp_Err
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, Data_Valid, Par_Err, Stp_Err
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-of-3 majority per bit, optional even/odd parity,
// registered one-cycle status pulses and early stop-bit exit for back-to-back frames.
module uart_rx #(
   parameter int Data_Width = 8,
   parameter int OVERSAMPLE = 8
) (
   input logic      CLK,
   input logic      RST,
   uart_rx_if.slave bus
);

   localparam int EW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

   localparam logic [EW-1:0] E_S0   = EW'(OVERSAMPLE / 2 - 1);
   localparam logic [EW-1:0] E_S1   = EW'(OVERSAMPLE / 2);
   localparam logic [EW-1:0] E_DEC  = EW'(OVERSAMPLE / 2 + 1);
   localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(Data_Width - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state, state_n;
   logic [EW-1:0]         edge_cnt, edge_n;
   logic [BW-1:0]         bit_cnt, bit_n;
   logic [1:0]            samp, samp_n;
   logic                  start_hi, start_hi_n;
   logic [Data_Width-1:0] shift, shift_n;
   logic                  par_en_l, par_en_n;
   logic                  par_typ_l, par_typ_n;
   logic                  par_err_l, par_err_n;
   logic [Data_Width-1:0] pdata_n;
   logic                  dv_n, pe_n, se_n;

   logic rx;
   logic maj;
   logic decide;
   logic last_edge;
   logic start_val;

   assign rx        = bus.RX_IN;
   assign decide    = (edge_cnt == E_DEC);
   assign last_edge = (edge_cnt == E_LAST);
   // third sample is the live input at the decision edge, not a stored one
   assign maj       = (samp[0] & samp[1]) | (samp[0] & rx) | (samp[1] & rx);
   // with OVERSAMPLE=4 the decision and last edge coincide
   assign start_val = decide ? maj : start_hi;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         edge_cnt       <= '0;
         bit_cnt        <= '0;
         samp           <= '0;
         start_hi       <= 1'b0;
         shift          <= '0;
         par_en_l       <= 1'b0;
         par_typ_l      <= 1'b0;
         par_err_l      <= 1'b0;
         bus.P_DATA     <= '0;
         bus.Data_Valid <= 1'b0;
         bus.Par_Err    <= 1'b0;
         bus.Stp_Err    <= 1'b0;
      end else begin
         state          <= state_n;
         edge_cnt       <= edge_n;
         bit_cnt        <= bit_n;
         samp           <= samp_n;
         start_hi       <= start_hi_n;
         shift          <= shift_n;
         par_en_l       <= par_en_n;
         par_typ_l      <= par_typ_n;
         par_err_l      <= par_err_n;
         bus.P_DATA     <= pdata_n;
         bus.Data_Valid <= dv_n;
         bus.Par_Err    <= pe_n;
         bus.Stp_Err    <= se_n;
      end
   end

   always_comb begin
      state_n    = state;
      edge_n     = edge_cnt;
      bit_n      = bit_cnt;
      samp_n     = samp;
      start_hi_n = start_hi;
      shift_n    = shift;
      par_en_n   = par_en_l;
      par_typ_n  = par_typ_l;
      par_err_n  = par_err_l;
      pdata_n    = bus.P_DATA;
      dv_n       = 1'b0;
      pe_n       = 1'b0;
      se_n       = 1'b0;

      if (state != IDLE) begin
         edge_n = last_edge ? '0 : edge_cnt + 1'b1;
         if (edge_cnt == E_S0) samp_n[0] = rx;
         if (edge_cnt == E_S1) samp_n[1] = rx;
      end

      case (state)
         IDLE: begin
            edge_n = '0;
            bit_n  = '0;
            if (!rx) begin
               state_n   = START;
               edge_n    = EW'(1);
               par_en_n  = bus.PAR_EN;
               par_typ_n = bus.PAR_TYP;
               par_err_n = 1'b0;
            end
         end

         START: begin
            if (decide) start_hi_n = maj;
            if (last_edge) begin
               state_n = start_val ? IDLE : DATA;
               bit_n   = '0;
            end
         end

         DATA: begin
            if (decide) begin
               shift_n                 = shift >> 1;
               shift_n[Data_Width-1]   = maj;
            end
            if (last_edge) begin
               if (bit_cnt == B_LAST) begin
                  state_n = par_en_l ? PARITY : STOP;
                  bit_n   = '0;
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end
         end

         PARITY: begin
            if (decide) par_err_n = (maj != ((^shift) ^ par_typ_l));
            if (last_edge) state_n = STOP;
         end

         STOP: begin
            // leave at the decision edge so a following start bit is not missed
            if (decide) begin
               state_n = IDLE;
               edge_n  = '0;
               dv_n    = !par_err_l && maj;
               pe_n    = par_err_l;
               se_n    = !maj;
               if (!par_err_l && maj) pdata_n = shift;
            end
         end

         default: begin
            state_n = IDLE;
            edge_n  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, parity/stop errors, glitch rejection,
// configuration latching, back-to-back frames and mid-frame reset.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
   int dv_cyc = -1, dv_prev = -1, pe_cyc = -1, se_cyc = -1;

   uart_rx_if #(.Data_Width(8)) bus_i ();

   uart_rx #(
      .Data_Width(8),
      .OVERSAMPLE(8)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus_i.Data_Valid) begin
         dv_cnt  = dv_cnt + 1;
         dv_prev = dv_cyc;
         dv_cyc  = cyc;
      end
      if (bus_i.Par_Err) begin
         pe_cnt = pe_cnt + 1;
         pe_cyc = cyc;
      end
      if (bus_i.Stp_Err) begin
         se_cnt = se_cnt + 1;
         se_cyc = cyc;
      end
   end

   task automatic idle(input int n);
      bus_i.RX_IN = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends nbits bits of a frame (start, 8 data LSB first, optional parity, stop).
   // gbit selects a bit to invert for one cycle at edge 4; flip toggles PAR_EN after start.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic pbit, input logic sbit, input int gbit,
                             input int nbits, input logic flip, output int t0);
      int   nb;
      logic b;
      nb = pen ? 11 : 10;
      if (nbits < nb) nb = nbits;
      bus_i.PAR_EN  = pen;
      bus_i.PAR_TYP = ptyp;
      t0 = cyc;
      for (int i = 0; i < nb; i++) begin
         if (i == 0)             b = 1'b0;
         else if (i <= 8)        b = d[i-1];
         else if (pen && i == 9) b = pbit;
         else                    b = sbit;
         if (flip && i == 1) begin
            bus_i.PAR_EN  = ~pen;
            bus_i.PAR_TYP = ~ptyp;
         end
         for (int e = 0; e < 8; e++) begin
            bus_i.RX_IN = (i == gbit && e == 4) ? ~b : b;
            @(posedge clk);
            #1;
         end
      end
      bus_i.RX_IN = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus_i.RX_IN = 1'b1;
      bus_i.PAR_EN = 1'b0;
      bus_i.PAR_TYP = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (bus_i.P_DATA !== 8'h00) $display("FAIL reset_pdata: got %h expected 00", bus_i.P_DATA); else passed++;
      checks++; if (bus_i.Data_Valid !== 1'b0) $display("FAIL reset_dv: got %b expected 0", bus_i.Data_Valid); else passed++;
      checks++; if (bus_i.Par_Err !== 1'b0) $display("FAIL reset_pe: got %b expected 0", bus_i.Par_Err); else passed++;
      checks++; if (bus_i.Stp_Err !== 1'b0) $display("FAIL reset_se: got %b expected 0", bus_i.Stp_Err); else passed++;
   endtask

   task automatic test_good_parity;
      int t0, dv0, pe0, se0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (dv_cnt - dv0 !== 1) $display("FAIL good_dv_count: got %0d expected 1", dv_cnt - dv0); else passed++;
      checks++; if (dv_cyc - t0 !== 86) $display("FAIL good_dv_latency: got %0d expected 86", dv_cyc - t0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'hA5) $display("FAIL good_pdata: got %h expected a5", bus_i.P_DATA); else passed++;
      checks++; if (pe_cnt - pe0 !== 0) $display("FAIL good_no_pe: got %0d expected 0", pe_cnt - pe0); else passed++;
      checks++; if (se_cnt - se0 !== 0) $display("FAIL good_no_se: got %0d expected 0", se_cnt - se0); else passed++;
   endtask

   task automatic test_parity_error;
      int t0, dv0, pe0;
      dv0 = dv_cnt; pe0 = pe_cnt;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (pe_cnt - pe0 !== 1) $display("FAIL perr_count: got %0d expected 1", pe_cnt - pe0); else passed++;
      checks++; if (pe_cyc - t0 !== 86) $display("FAIL perr_latency: got %0d expected 86", pe_cyc - t0); else passed++;
      checks++; if (dv_cnt - dv0 !== 0) $display("FAIL perr_no_dv: got %0d expected 0", dv_cnt - dv0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'hA5) $display("FAIL perr_hold: got %h expected a5", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_stop_error;
      int t0, dv0, se0;
      dv0 = dv_cnt; se0 = se_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (se_cnt - se0 !== 1) $display("FAIL serr_count: got %0d expected 1", se_cnt - se0); else passed++;
      checks++; if (se_cyc - t0 !== 78) $display("FAIL serr_latency: got %0d expected 78", se_cyc - t0); else passed++;
      checks++; if (dv_cnt - dv0 !== 0) $display("FAIL serr_no_dv: got %0d expected 0", dv_cnt - dv0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'hA5) $display("FAIL serr_hold: got %h expected a5", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_odd_parity;
      int t0, dv0;
      dv0 = dv_cnt;
      // 0x3C has four ones, so odd parity needs a 1
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (dv_cnt - dv0 !== 1) $display("FAIL odd_dv_count: got %0d expected 1", dv_cnt - dv0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'h3C) $display("FAIL odd_pdata: got %h expected 3c", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_start_glitch;
      int t0, tot0;
      tot0 = dv_cnt + pe_cnt + se_cnt;
      bus_i.RX_IN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle(12);
      checks++; if (dv_cnt + pe_cnt + se_cnt - tot0 !== 0) $display("FAIL glitch_no_pulse: got %0d expected 0", dv_cnt + pe_cnt + se_cnt - tot0); else passed++;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (dv_cyc - t0 !== 78) $display("FAIL glitch_next_latency: got %0d expected 78", dv_cyc - t0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'h55) $display("FAIL glitch_next_pdata: got %h expected 55", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_majority;
      int t0;
      // bit 3 of 0xA5 is 0; frame bit index 4 carries it
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 4, 99, 1'b0, t0);
      idle(12);
      checks++; if (bus_i.P_DATA !== 8'hA5) $display("FAIL majority_pdata: got %h expected a5", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_cfg_latch;
      int t0, dv0, pe0;
      dv0 = dv_cnt; pe0 = pe_cnt;
      send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 99, 1'b1, t0);
      idle(12);
      checks++; if (dv_cyc - t0 !== 78) $display("FAIL latch_latency: got %0d expected 78", dv_cyc - t0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'h96) $display("FAIL latch_pdata: got %h expected 96", bus_i.P_DATA); else passed++;
      checks++; if (dv_cnt - dv0 !== 1 || pe_cnt - pe0 !== 0) $display("FAIL latch_pulses: got dv=%0d pe=%0d expected dv=1 pe=0", dv_cnt - dv0, pe_cnt - pe0); else passed++;
   endtask

   task automatic test_back_to_back;
      int t0, t1, dv0;
      dv0 = dv_cnt;
      // ten-bit frames with a full stop bit put the pulses 10*8 cycles apart
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 99, 1'b0, t0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 99, 1'b0, t1);
      idle(12);
      checks++; if (dv_cnt - dv0 !== 2) $display("FAIL b2b_count: got %0d expected 2", dv_cnt - dv0); else passed++;
      checks++; if (dv_cyc - dv_prev !== 80) $display("FAIL b2b_gap: got %0d expected 80", dv_cyc - dv_prev); else passed++;
      checks++; if (bus_i.P_DATA !== 8'hFF) $display("FAIL b2b_pdata: got %h expected ff", bus_i.P_DATA); else passed++;
   endtask

   task automatic test_reset_mid_frame;
      int t0, t1, dv0;
      dv0 = dv_cnt;
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, -1, 99, 1'b0, t0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, -1, 5, 1'b0, t1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(100);
      checks++; if (dv_cnt - dv0 !== 1) $display("FAIL rstmid_count: got %0d expected 1", dv_cnt - dv0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'h00) $display("FAIL rstmid_pdata: got %h expected 00", bus_i.P_DATA); else passed++;
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, -1, 99, 1'b0, t0);
      idle(12);
      checks++; if (dv_cyc - t0 !== 86) $display("FAIL rstmid_restart_latency: got %0d expected 86", dv_cyc - t0); else passed++;
      checks++; if (bus_i.P_DATA !== 8'h5A) $display("FAIL rstmid_restart_pdata: got %h expected 5a", bus_i.P_DATA); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      bus_i.RX_IN = 1'b1;
      bus_i.PAR_EN = 1'b0;
      bus_i.PAR_TYP = 1'b0;
      @(posedge clk);
      #1;
      test_reset;
      test_good_parity;
      test_parity_error;
      test_stop_error;
      test_odd_parity;
      test_start_glitch;
      test_majority;
      test_cfg_latch;
      test_back_to_back;
      test_reset_mid_frame;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
